soc_timer: RTL and testbench

SOC_TIMER -- requirements
Module: soc_timer

---
 rtl/soc_timer.sv | 166 ++++++++++++++++
 tb/tb_soc_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_timer.sv
// soc_timer: bus-mapped 32-bit timer with prescaler,
// compare-match pending flag and level interrupt.
module soc_timer #(
  parameter logic [4:0] IRQ_ID      = 5'd16,
  parameter int         PRESC_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i
);

  localparam int PW = PRESC_WIDTH;

  logic [2:0]    ctrl;
  logic [31:0]   count;
  logic [31:0]   compare;
  logic          pending;
  logic [PW-1:0] presc;
  logic [PW-1:0] psc_cnt;

  logic [2:0]  off;
  logic        sel_ctrl;
  logic        sel_count;
  logic        sel_cmp;
  logic        sel_stat;
  logic        sel_presc;
  logic        mapped;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_count;
  logic        wr_cmp;
  logic        wr_stat;
  logic        wr_presc;
  logic [31:0] bmask;
  logic [31:0] presc_ext;
  logic [31:0] count_wr;
  logic [31:0] cmp_wr;
  logic [31:0] presc_wr;
  logic [31:0] rd_val;
  logic        tick;
  logic        match;
  logic        w1c;
  logic        ack_hit;
  logic        unused_bits;

  assign off       = addr_i[4:2];
  assign sel_ctrl  = (off == 3'd0);
  assign sel_count = (off == 3'd1);
  assign sel_cmp   = (off == 3'd2);
  assign sel_stat  = (off == 3'd3);
  assign sel_presc = (off == 3'd4);
  assign mapped    = sel_ctrl | sel_count | sel_cmp
                   | sel_stat | sel_presc;

  // An all-zero byte enable is a response-only no-op.
  assign wr       = req_i & we_i & (|be_i) & mapped;
  assign wr_ctrl  = wr & sel_ctrl;
  assign wr_count = wr & sel_count;
  assign wr_cmp   = wr & sel_cmp;
  assign wr_stat  = wr & sel_stat;
  assign wr_presc = wr & sel_presc;

  assign bmask = {{8{be_i[3]}}, {8{be_i[2]}},
                  {8{be_i[1]}}, {8{be_i[0]}}};

  assign presc_ext = {{(32-PW){1'b0}}, presc};
  assign count_wr  = (count & ~bmask)
                   | (wdata_i & bmask);
  assign cmp_wr    = (compare & ~bmask)
                   | (wdata_i & bmask);
  assign presc_wr  = (presc_ext & ~bmask)
                   | (wdata_i & bmask);

  assign tick    = ctrl[0] & (psc_cnt == presc);
  assign match   = tick & (count == compare);
  assign w1c     = wr_stat & be_i[0] & wdata_i[0];
  assign ack_hit = irq_ack_i & (irq_id_i == IRQ_ID);

  assign gnt_o    = req_i;
  assign irq_o    = pending & ctrl[1];
  assign irq_id_o = IRQ_ID;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0],
                         presc_wr[31:PW]};

  // Read mux: register values as seen in the grant cycle.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ctrl:  rd_val = {29'd0, ctrl};
      sel_count: rd_val = count;
      sel_cmp:   rd_val = compare;
      sel_stat:  rd_val = {31'd0, pending};
      sel_presc: rd_val = presc_ext;
      default:   rd_val = '0;
    endcase
  end

  // One-cycle response for every granted transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= req_i;
      err_o    <= req_i & ~mapped;
      rdata_o  <= (req_i & ~we_i & mapped)
                ? rd_val : '0;
    end
  end

  // Configuration registers written from the bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl    <= '0;
      compare <= 32'hFFFF_FFFF;
      presc   <= '0;
    end else begin
      if (wr_ctrl && be_i[0]) ctrl <= wdata_i[2:0];
      if (wr_cmp)   compare <= cmp_wr;
      if (wr_presc) presc   <= presc_wr[PW-1:0];
    end
  end

  // Prescaler and counter; a COUNT write beats a tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_cnt <= '0;
      count   <= '0;
    end else begin
      if (wr_count || wr_presc)
        psc_cnt <= '0;
      else if (ctrl[0])
        psc_cnt <= tick ? '0 : psc_cnt + PW'(1);
      if (wr_count)
        count <= count_wr;
      else if (tick)
        count <= (match && ctrl[2])
               ? '0 : count + 32'd1;
    end
  end

  // Pending flag; a match in the same cycle beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      pending <= 1'b0;
    else if (match)
      pending <= 1'b1;
    else if (w1c || ack_hit)
      pending <= 1'b0;
  end

endmodule

// File: tb/tb_soc_timer.sv
// tb_soc_timer: random and directed bus traffic
// checked every cycle against a behavioural model.
module tb_soc_timer;

  localparam logic [4:0] IRQ_ID = 5'd16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        err;
  logic        irq;
  logic [4:0]  irq_id;
  logic        ack = 1'b0;
  logic [4:0]  ack_id = '0;

  soc_timer #(.IRQ_ID(IRQ_ID), .PRESC_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid),
    .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata), .err_o(err),
    .irq_o(irq), .irq_id_o(irq_id),
    .irq_ack_i(ack), .irq_id_i(ack_id)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: register contents and expected response.
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_cmp, m_rdata;
  logic        m_pend, m_rvalid, m_err;
  int unsigned m_presc, m_psc;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h",
               nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] nw,
      input logic [3:0]  en);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Advance the model by one clock edge using current inputs.
  task automatic model_step();
    int          off;
    bit          tick, match, wr, clr;
    logic [31:0] rv, n_count, n_cmp;
    logic [2:0]  n_ctrl;
    int unsigned n_psc, n_presc;
    if (rst) begin
      m_ctrl = '0; m_count = '0; m_cmp = 32'hFFFF_FFFF;
      m_pend = 1'b0; m_presc = 0; m_psc = 0;
      m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0;
      return;
    end
    off = int'(addr[4:2]);
    case (off)
      0: rv = {29'd0, m_ctrl};
      1: rv = m_count;
      2: rv = m_cmp;
      3: rv = {31'd0, m_pend};
      4: rv = 32'(m_presc);
      default: rv = '0;
    endcase
    tick  = m_ctrl[0] && (m_psc == m_presc);
    match = tick && (m_count == m_cmp);
    n_psc = m_ctrl[0] ? (tick ? 0 : m_psc + 1) : m_psc;
    n_count = m_count;
    if (tick) n_count = (match && m_ctrl[2]) ? 32'd0
                                              : m_count + 32'd1;
    n_ctrl = m_ctrl; n_cmp = m_cmp; n_presc = m_presc;
    clr = ack && (ack_id == IRQ_ID);
    wr  = req && we && (be != 4'd0) && (off <= 4);
    if (wr) begin
      case (off)
        0: if (be[0]) n_ctrl = wdata[2:0];
        1: begin n_count = merge(m_count, wdata, be); n_psc = 0; end
        2: n_cmp = merge(m_cmp, wdata, be);
        3: if (be[0] && wdata[0]) clr = 1'b1;
        4: begin
             n_presc = merge(32'(m_presc), wdata, be) & 32'hFF;
             n_psc = 0;
           end
        default: ;
      endcase
    end
    if (clr) m_pend = 1'b0;
    if (match) m_pend = 1'b1;
    m_rvalid = req;
    m_err    = req && (off > 4);
    m_rdata  = (req && !we && off <= 4) ? rv : 32'd0;
    m_ctrl = n_ctrl; m_count = n_count; m_cmp = n_cmp;
    m_presc = n_presc; m_psc = n_psc;
  endtask

  // One cycle: check grant, advance model, compare outputs.
  task automatic step();
    #1;
    chk("gnt", 32'(gnt), 32'(req));
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("err", 32'(err), 32'(m_err));
    if (m_rvalid) chk("rdata", rdata, m_rdata);
    chk("irq", 32'(irq), 32'(m_pend & m_ctrl[1]));
    chk("irq_id", 32'(irq_id), 32'(IRQ_ID));
  endtask

  task automatic bus(input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    step();
    req = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    @(negedge clk);
    idle(2);

    // Transfer granted during reset: discarded, no response.
    req = 1'b1; we = 1'b1; addr = 32'h8;
    wdata = 32'h1234; be = 4'hF;
    step();
    chk("rst_no_rvalid", 32'(rvalid), 32'd0);
    req = 1'b0; we = 1'b0; be = '0;
    rst = 1'b0;

    bus(1'b0, 32'h8, '0, '0);
    chk("cmp_rst_rvalid", 32'(rvalid), 32'd1);
    chk("cmp_rst_rdata", rdata, 32'hFFFF_FFFF);
    chk("cmp_rst_err", 32'(err), 32'd0);

    bus(1'b1, 32'h10, 32'd3, 4'hF);
    bus(1'b1, 32'h08, 32'd2, 4'hF);
    bus(1'b1, 32'h00, 32'd7, 4'hF);
    idle(11);
    chk("irq_before_3rd_tick", 32'(irq), 32'd0);
    idle(1);
    chk("irq_at_3rd_tick", 32'(irq), 32'd1);
    bus(1'b0, 32'h4, '0, '0);
    chk("count_reloaded", rdata, 32'd0);

    ack = 1'b1; ack_id = IRQ_ID - 5'd1;
    step();
    ack = 1'b0;
    chk("irq_wrong_ack", 32'(irq), 32'd1);
    ack = 1'b1; ack_id = IRQ_ID;
    step();
    ack = 1'b0;
    chk("irq_acked", 32'(irq), 32'd0);

    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (m_ctrl[0] && m_psc == m_presc && m_count == m_cmp) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("match_reached", 32'(found), 32'd1);
    bus(1'b1, 32'hC, 32'd1, 4'hF);
    chk("set_beats_w1c", 32'(irq), 32'd1);
    bus(1'b1, 32'hC, 32'd1, 4'hF);
    chk("w1c_clears", 32'(irq), 32'd0);

    bus(1'b1, 32'h00, 32'd0, 4'hF);
    bus(1'b1, 32'h10, 32'd0, 4'hF);
    bus(1'b1, 32'h08, 32'd5, 4'hF);
    bus(1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF);
    bus(1'b1, 32'h00, 32'd1, 4'hF);
    bus(1'b0, 32'h04, '0, '0);
    chk("count_max", rdata, 32'hFFFF_FFFF);
    bus(1'b0, 32'h04, '0, '0);
    chk("count_wrapped", rdata, 32'd0);
    bus(1'b0, 32'h0C, '0, '0);
    chk("no_pend_on_wrap", rdata, 32'd0);

    bus(1'b0, 32'h1C, '0, '0);
    chk("unmapped_err", 32'(err), 32'd1);
    chk("unmapped_rdata", rdata, 32'd0);
    bus(1'b0, 32'h04, '0, '0);
    chk("b2b_rvalid", 32'(rvalid), 32'd1);
    chk("b2b_err", 32'(err), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int o;
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 1) == 1);
      o   = int'($urandom_range(0, 7));
      addr = $urandom;
      addr[4:2] = 3'(o);
      be = ($urandom_range(0, 3) == 0)
         ? 4'($urandom_range(0, 15)) : 4'hF;
      case (o)
        0: wdata = ($urandom_range(0, 3) == 0)
                 ? $urandom : 32'($urandom_range(0, 7)) | 32'd1;
        1: wdata = ($urandom_range(0, 7) == 0)
                 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                 : 32'($urandom_range(0, 6));
        2: wdata = 32'($urandom_range(0, 6));
        4: wdata = ($urandom_range(0, 7) == 0)
                 ? $urandom : 32'($urandom_range(0, 3));
        default: wdata = $urandom;
      endcase
      ack = ($urandom_range(0, 9) == 0);
      ack_id = ($urandom_range(0, 1) == 1) ? IRQ_ID
                                           : IRQ_ID - 5'd1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
